// File: rtl/gaussian_blur_sep.sv
// Separable Gaussian blur over a row-per-word image SRAM: a KSIZE-row line buffer feeds a
// vertical pass, then a horizontal pass, with zero or edge-replicate borders.
module gaussian_blur_sep #(
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int PIX_W  = 8,
    parameter int KSIZE  = 7,
    parameter int COEF_W = 16,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            border_mode,
    input  logic [(KSIZE/2+1)*COEF_W-1:0]   coef,
    output logic                            busy,
    output logic                            done,
    output logic                            img_re,
    output logic [ADDR_W-1:0]               img_addr,
    input  logic [COLS*PIX_W-1:0]           img_dout,
    output logic                            blur_we,
    output logic [ADDR_W-1:0]               blur_addr,
    output logic [COLS*PIX_W-1:0]           blur_din,
    input  logic                            out_ready
);

    localparam int HALF  = KSIZE / 2;
    localparam int V_W   = PIX_W + COEF_W + 3;
    localparam int H_W   = PIX_W + 2 * COEF_W + 6;
    localparam int SRC_W = $clog2(ROWS + KSIZE) + 1;
    localparam int PAD_N = COLS + 2 * HALF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_LOAD = 3'd3,
        ST_VSUM = 3'd4,
        ST_HSUM = 3'd5,
        ST_WR   = 3'd6
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [COLS*PIX_W-1:0]  lb_r [KSIZE];
    logic [COLS*PIX_W-1:0]  rd_row_r;
    logic [COEF_W-1:0]      coef_r [HALF+1];
    logic                   mode_r;
    logic [SRC_W-1:0]       src_r;
    logic [ADDR_W-1:0]      y_r;
    logic [V_W-1:0]         v_r [COLS];
    logic [COLS*PIX_W-1:0]  pix_r;
    logic                   done_r;

    logic                   src_valid_s;
    logic                   last_row_s;
    logic [V_W-1:0]         v_sum_s [COLS];
    logic [V_W-1:0]         v_pad_s [PAD_N];
    logic [H_W-1:0]         h_sum_s [COLS];
    logic [COLS*PIX_W-1:0]  pix_s;

    // Tap index k (0..KSIZE-1, centre at HALF) to coefficient slice |k-HALF|.
    function automatic int tap(input int k);
        if (k < HALF) begin
            return HALF - k;
        end else begin
            return k - HALF;
        end
    endfunction

    // Drop 2*COEF_W fraction bits with round-half-up, then clamp to the pixel range.
    function automatic logic [PIX_W-1:0] round_sat(input logic [H_W-1:0] h);
        logic [H_W:0] sum;
        logic [H_W:0] q;
        sum = {1'b0, h} + ((H_W+1)'(1'b1) << (2 * COEF_W - 1));
        q   = sum >> (2 * COEF_W);
        if (q > (H_W+1)'({PIX_W{1'b1}})) begin
            return {PIX_W{1'b1}};
        end else begin
            return q[PIX_W-1:0];
        end
    endfunction

    assign src_valid_s = (src_r < SRC_W'(ROWS));
    assign last_row_s  = (y_r == ADDR_W'(ROWS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a load repeats until the centre row (src = HALF) is buffered.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_RD;
                else       next_state_s = ST_IDLE;
            end
            ST_RD:   next_state_s = ST_LAT;
            ST_LAT:  next_state_s = ST_LOAD;
            ST_LOAD: begin
                if (src_r < SRC_W'(HALF)) next_state_s = ST_RD;
                else                      next_state_s = ST_VSUM;
            end
            ST_VSUM: next_state_s = ST_HSUM;
            ST_HSUM: next_state_s = ST_WR;
            ST_WR: begin
                if (!out_ready)      next_state_s = ST_WR;
                else if (last_row_s) next_state_s = ST_IDLE;
                else                 next_state_s = ST_RD;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Vertical pass: line buffer slot k holds row y + (k - HALF).
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            v_sum_s[c] = '0;
            for (int k = 0; k < KSIZE; k++) begin
                v_sum_s[c] = v_sum_s[c]
                           + V_W'(coef_r[tap(k)]) * V_W'(lb_r[k][c*PIX_W +: PIX_W]);
            end
        end
    end

    // Column-padded vertical sums so the horizontal pass needs no range checks.
    always_comb begin
        for (int c = 0; c < PAD_N; c++) begin
            if (c < HALF) begin
                v_pad_s[c] = mode_r ? v_r[0] : '0;
            end else if (c >= COLS + HALF) begin
                v_pad_s[c] = mode_r ? v_r[COLS-1] : '0;
            end else begin
                v_pad_s[c] = v_r[c-HALF];
            end
        end
    end

    // Horizontal pass and output rounding.
    always_comb begin
        pix_s = '0;
        for (int c = 0; c < COLS; c++) begin
            h_sum_s[c] = '0;
            for (int k = 0; k < KSIZE; k++) begin
                h_sum_s[c] = h_sum_s[c] + H_W'(coef_r[tap(k)]) * H_W'(v_pad_s[c+k]);
            end
            pix_s[c*PIX_W +: PIX_W] = round_sat(h_sum_s[c]);
        end
    end

    // Datapath: configuration latch, row loading, pass registers and row bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KSIZE; k++) lb_r[k] <= '0;
            for (int i = 0; i <= HALF; i++) coef_r[i] <= '0;
            for (int c = 0; c < COLS; c++) v_r[c] <= '0;
            rd_row_r <= '0;
            mode_r   <= 1'b0;
            src_r    <= '0;
            y_r      <= '0;
            pix_r    <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= border_mode;
                        for (int i = 0; i <= HALF; i++) coef_r[i] <= coef[i*COEF_W +: COEF_W];
                        src_r  <= '0;
                        y_r    <= '0;
                    end
                end
                ST_LAT: rd_row_r <= img_dout;
                ST_LOAD: begin
                    if (src_r == '0) begin
                        // First row of a frame also seeds the rows above the image.
                        for (int k = 0; k < KSIZE - 1; k++) lb_r[k] <= mode_r ? rd_row_r : '0;
                        lb_r[KSIZE-1] <= rd_row_r;
                    end else begin
                        for (int k = 0; k < KSIZE - 1; k++) lb_r[k] <= lb_r[k+1];
                        if (src_valid_s) lb_r[KSIZE-1] <= rd_row_r;
                        else if (mode_r) lb_r[KSIZE-1] <= lb_r[KSIZE-1];
                        else             lb_r[KSIZE-1] <= '0;
                    end
                    if (src_r < SRC_W'(HALF)) src_r <= src_r + SRC_W'(1'b1);
                end
                ST_VSUM: begin
                    for (int c = 0; c < COLS; c++) v_r[c] <= v_sum_s[c];
                end
                ST_HSUM: pix_r <= pix_s;
                ST_WR: begin
                    if (out_ready) begin
                        if (last_row_s) begin
                            done_r <= 1'b1;
                        end else begin
                            y_r   <= y_r + ADDR_W'(1'b1);
                            src_r <= SRC_W'(y_r) + SRC_W'(HALF + 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign img_re    = (state_r == ST_RD) && src_valid_s;
    assign img_addr  = img_re ? src_r[ADDR_W-1:0] : '0;
    assign blur_we   = (state_r == ST_WR) && out_ready;
    assign blur_addr = y_r;
    assign blur_din  = pix_r;

endmodule

// File: tb/tb_gaussian_blur_sep.sv
// Directed bench for gaussian_blur_sep on a 4x4 image with a 3-tap kernel; expected
// images, write cycles and done cycles are hand-computed constants.
module tb_gaussian_blur_sep;

    localparam int COLS   = 4;
    localparam int ROWS   = 4;
    localparam int PIX_W  = 8;
    localparam int KSIZE  = 3;
    localparam int COEF_W = 8;
    localparam int ADDR_W = 2;
    localparam int ROW_W  = COLS * PIX_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               border_mode = 1'b0;
    logic [15:0]        coef = 16'd0;
    logic               busy, done, img_re, blur_we;
    logic [ADDR_W-1:0]  img_addr, blur_addr;
    logic [ROW_W-1:0]   img_dout = '0;
    logic [ROW_W-1:0]   blur_din;
    logic               out_ready = 1'b1;

    logic [ROW_W-1:0]   img_mem  [ROWS];
    logic [ROW_W-1:0]   exp_rows [ROWS];
    logic [ROW_W-1:0]   wdata [8];
    int                 waddr [8];
    int                 wcyc  [8];
    int                 re_addr [8];
    int                 wn, re_n, done_n, done_cyc, busy_err;
    int                 n_cmp = 0;
    int                 n_err = 0;

    gaussian_blur_sep #(
        .COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W), .KSIZE(KSIZE),
        .COEF_W(COEF_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .border_mode(border_mode), .coef(coef),
        .busy(busy), .done(done), .img_re(img_re), .img_addr(img_addr),
        .img_dout(img_dout), .blur_we(blur_we), .blur_addr(blur_addr),
        .blur_din(blur_din), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Image SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (img_re) img_dout <= img_mem[img_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] pack4(input int p0, input int p1, input int p2, input int p3);
        return {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endfunction

    task automatic fill_image(input int v);
        for (int r = 0; r < ROWS; r++) img_mem[r] = pack4(v, v, v, v);
    endtask

    task automatic expect_const(input int v);
        for (int r = 0; r < ROWS; r++) exp_rows[r] = pack4(v, v, v, v);
    endtask

    // Runs one frame for 90 cycles; cycle 1 is the first cycle after the accepting edge.
    task automatic run_frame(input string name, input logic mode, input logic [15:0] cf,
                             input int stall_len, input int restart_cyc, input int rst_cyc);
        int first_wr;
        int done_exp;
        first_wr = 9 + stall_len;
        done_exp = 28 + stall_len;
        wn = 0; re_n = 0; done_n = 0; done_cyc = -1; busy_err = 0;
        border_mode = mode;
        coef = cf;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            out_ready = !(stall_len > 0 && cyc >= 9 && cyc < 9 + stall_len);
            start = (cyc == restart_cyc);
            rst = (cyc == rst_cyc);
            #1;
            if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
                check_eq({name, "_rst_outs"},
                         {busy, done, img_re, img_addr, blur_we, blur_addr, blur_din},
                         '0);
            end
            if (stall_len > 0 && !out_ready) begin
                check_eq({name, "_stall_we"}, blur_we, 1'b0);
                check_eq({name, "_stall_addr"}, blur_addr, 0);
                check_eq({name, "_stall_din"}, blur_din, exp_rows[0]);
            end
            if (rst_cyc == 0 && busy !== (cyc < done_exp)) busy_err++;
            if (blur_we) begin
                if (wn < 8) begin
                    wdata[wn] = blur_din;
                    waddr[wn] = blur_addr;
                    wcyc[wn]  = cyc;
                end
                wn++;
            end
            if (img_re) begin
                if (re_n < 8) re_addr[re_n] = img_addr;
                re_n++;
            end
            if (done) begin
                if (done_n == 0) done_cyc = cyc;
                done_n++;
            end
        end
        start = 1'b0;
        rst = 1'b0;
        if (rst_cyc > 0) begin
            check_eq({name, "_nwr"}, wn, 2);
            check_eq({name, "_ndone"}, done_n, 0);
        end else begin
            check_eq({name, "_nwr"}, wn, 4);
            for (int i = 0; i < 4 && i < wn; i++) begin
                check_eq($sformatf("%s_wcyc%0d", name, i), wcyc[i], first_wr + 6 * i);
                check_eq($sformatf("%s_waddr%0d", name, i), waddr[i], i);
                check_eq($sformatf("%s_wdata%0d", name, i), wdata[i], exp_rows[i]);
            end
            check_eq({name, "_ndone"}, done_n, 1);
            check_eq({name, "_done_cyc"}, done_cyc, done_exp);
            check_eq({name, "_busy"}, busy_err, 0);
            check_eq({name, "_nre"}, re_n, 4);
            for (int i = 0; i < 4 && i < re_n; i++) begin
                check_eq($sformatf("%s_readdr%0d", name, i), re_addr[i], i);
            end
        end
    endtask

    initial begin
        fill_image(0);
        expect_const(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_outs", {busy, done, img_re, img_addr, blur_we, blur_addr, blur_din}, '0);

        // Replicate border, flat image; a second start mid-frame must be ignored.
        fill_image(100);
        expect_const(100);
        run_frame("rep_flat", 1'b1, {8'd64, 8'd128}, 0, 12, 0);

        // Zero border darkens edges and corners of a flat image.
        exp_rows[0] = pack4(56, 75, 75, 56);
        exp_rows[1] = pack4(75, 100, 100, 75);
        exp_rows[2] = pack4(75, 100, 100, 75);
        exp_rows[3] = pack4(56, 75, 75, 56);
        run_frame("zero_flat", 1'b0, {8'd64, 8'd128}, 0, 0, 0);

        // Impulse response.
        fill_image(0);
        img_mem[2] = pack4(0, 0, 255, 0);
        exp_rows[0] = pack4(0, 0, 0, 0);
        exp_rows[1] = pack4(0, 16, 32, 16);
        exp_rows[2] = pack4(0, 32, 64, 32);
        exp_rows[3] = pack4(0, 16, 32, 16);
        run_frame("impulse", 1'b0, {8'd64, 8'd128}, 0, 0, 0);

        // Oversized kernel saturates.
        fill_image(200);
        expect_const(255);
        run_frame("saturate", 1'b1, {8'd255, 8'd255}, 0, 0, 0);

        // Sink back-pressure on the first row.
        fill_image(100);
        expect_const(100);
        run_frame("stall", 1'b1, {8'd64, 8'd128}, 5, 0, 0);

        // Reset between the row 1 and row 2 writes aborts the frame.
        run_frame("midrst", 1'b1, {8'd64, 8'd128}, 0, 0, 18);

        // A fresh frame after the abort behaves like the first one.
        run_frame("rerun", 1'b1, {8'd64, 8'd128}, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
